// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I types for the fetch stage
//
// Provides the PC/instruction word types, the fetch FSM state enum and the
// sequential PC step used by if_stage and if_hold_buf.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [31:0] rv32i_pc_word;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } if_state_t;

  localparam rv32i_pc_word PC_STEP = 32'd4;

endpackage

// File: rtl/if_hold_buf.sv
// rtl/if_hold_buf.sv - instruction/PC holding register for a stalled fetch
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears buffer)
//   load            capture instr_in/pc_in
//   clear           drop buffer contents (load wins if both asserted)
//   instr_in, pc_in data to capture
//   instr, pc       buffered contents
module if_hold_buf
  import rv32i_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  rv32i_word    instr_in,
  input  rv32i_pc_word pc_in,
  output rv32i_word    instr,
  output rv32i_pc_word pc
);

  always_ff @(posedge clk) begin
    if (rst || (clear && !load)) begin
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with stall hold and redirect discard
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall_id                      IF/ID register cannot load this cycle
//   redirect, redirect_pc         replace the fetch stream with redirect_pc
//   imem_read, imem_addr          instruction memory request (one outstanding)
//   imem_rdata, imem_resp         instruction memory response
//   load_if_id, pc_if, instr_if   presented instruction and its load strobe
//   fetch_count, discard_count    performance counters, only when
//                                 IF_STAGE_PERF_EN is defined
module if_stage
  import rv32i_types::*;
#(
  parameter rv32i_pc_word RESET_PC = 32'h4000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_id,
  input  logic         redirect,
  input  rv32i_pc_word redirect_pc,
  output logic         imem_read,
  output rv32i_pc_word imem_addr,
  input  rv32i_word    imem_rdata,
  input  logic         imem_resp,
  output logic         load_if_id,
  output rv32i_pc_word pc_if,
  output rv32i_word    instr_if
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0]  fetch_count,
  output logic [31:0]  discard_count
`endif
);

  if_state_t    state, state_nxt;
  rv32i_pc_word req_addr, req_nxt;
  rv32i_pc_word next_pc, npc_nxt;
  rv32i_word    hold_instr;
  rv32i_pc_word hold_pc;
  logic         hold_load, hold_clear;

  if_hold_buf u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .clear    (hold_clear),
    .instr_in (imem_rdata),
    .pc_in    (req_addr),
    .instr    (hold_instr),
    .pc       (hold_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      req_addr <= RESET_PC;
      next_pc  <= '0;
    end else begin
      state    <= state_nxt;
      req_addr <= req_nxt;
      next_pc  <= npc_nxt;
    end
  end

  // Redirect always wins; an unanswered request at redirect time must still
  // be drained (DISCARD) so that only one request is ever outstanding.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_addr;
    npc_nxt   = next_pc;
    case (state)
      FETCH: begin
        if (redirect) begin
          if (imem_resp) begin
            req_nxt = redirect_pc;
          end else begin
            state_nxt = DISCARD;
            npc_nxt   = redirect_pc;
          end
        end else if (imem_resp) begin
          if (stall_id) state_nxt = HOLD;
          else          req_nxt   = req_addr + PC_STEP;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_nxt = FETCH;
          req_nxt   = redirect_pc;
        end else if (!stall_id) begin
          state_nxt = FETCH;
          req_nxt   = hold_pc + PC_STEP;
        end
      end
      DISCARD: begin
        if (imem_resp) begin
          state_nxt = FETCH;
          req_nxt   = redirect ? redirect_pc : next_pc;
        end else if (redirect) begin
          npc_nxt = redirect_pc;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    imem_read  = !rst && (state != HOLD);
    imem_addr  = req_addr;
    load_if_id = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    pc_if      = req_addr;
    instr_if   = imem_rdata;
    if (state == HOLD) begin
      pc_if    = hold_pc;
      instr_if = hold_instr;
    end
    if (!rst) begin
      case (state)
        FETCH: begin
          if (imem_resp && !redirect) begin
            if (stall_id) hold_load  = 1'b1;
            else          load_if_id = 1'b1;
          end
        end
        HOLD: begin
          if (redirect)       hold_clear = 1'b1;
          else if (!stall_id) load_if_id = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef IF_STAGE_PERF_EN
  logic dropped;

  // A response is dropped in DISCARD or when it meets a redirect in FETCH;
  // a hold buffer is dropped when a redirect arrives in HOLD.
  assign dropped = !rst && ((imem_resp && (state == DISCARD || (state == FETCH && redirect)))
                            || (state == HOLD && redirect));

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count   <= '0;
      discard_count <= '0;
    end else begin
      fetch_count   <= fetch_count + {31'd0, load_if_id};
      discard_count <= discard_count + {31'd0, dropped};
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_id = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic        load_if_id;
  logic [31:0] pc_if;
  logic [31:0] instr_if;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] discard_count;
`endif

  if_stage #(.RESET_PC(32'h4000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_id    (stall_id),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_read   (imem_read),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .load_if_id  (load_if_id),
    .pc_if       (pc_if),
    .instr_if    (instr_if)
`ifdef IF_STAGE_PERF_EN
    ,
    .fetch_count   (fetch_count),
    .discard_count (discard_count)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a fetch stream pointer, an optional held instruction,
  // and an optional pending redirect target whose in-flight response is junk.
  logic [31:0] m_addr, m_target, m_hpc, m_hinstr;
  bit          m_holding, m_junk;
  logic [31:0] m_fetch, m_disc;

  // Last values seen by step(), for directed constant checks.
  logic [31:0] obs_addr, obs_pc;
  logic        obs_load;

  task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] rp,
                      input bit want_resp);
    bit          exp_read, exp_load;
    logic [31:0] exp_pc, exp_instr, rdata;
    @(posedge clk);
    #1;
    exp_read    = !r && !m_holding;
    rdata       = $urandom;
    rst         = r;
    stall_id    = st;
    redirect    = rd;
    redirect_pc = rp;
    imem_resp   = want_resp && exp_read;
    imem_rdata  = rdata;
    #1;
`ifdef IF_STAGE_PERF_EN
    if (!m_addr[0]) begin
      check_eq("fetch_count", fetch_count, m_fetch);
      check_eq("discard_count", discard_count, m_disc);
    end
`endif
    check_eq("imem_read", {31'd0, imem_read}, {31'd0, exp_read});
    if (exp_read) check_eq("imem_addr", imem_addr, m_addr);
    exp_load  = 1'b0;
    exp_pc    = m_addr;
    exp_instr = rdata;
    if (!r) begin
      if (m_holding) begin
        exp_pc    = m_hpc;
        exp_instr = m_hinstr;
        check_eq("hold_instr", instr_if, m_hinstr);
        exp_load  = !rd && !st;
      end else begin
        exp_load = want_resp && !rd && !st && !m_junk;
      end
    end
    check_eq("load_if_id", {31'd0, load_if_id}, {31'd0, exp_load});
    if (exp_load) begin
      check_eq("pc_if", pc_if, exp_pc);
      check_eq("instr_if", instr_if, exp_instr);
    end
    obs_addr = imem_addr;
    obs_pc   = pc_if;
    obs_load = load_if_id;
    // advance the model
    if (r) begin
      m_addr = 32'h4000_0000; m_holding = 0; m_junk = 0; m_fetch = 0; m_disc = 0;
    end else if (m_holding) begin
      if (rd) begin
        m_addr = rp; m_holding = 0; m_disc++;
      end else if (!st) begin
        m_addr = m_hpc + 32'd4; m_holding = 0; m_fetch++;
      end
    end else if (want_resp) begin
      if (m_junk || rd) begin
        m_disc++;
        m_addr = rd ? rp : m_target;
        m_junk = 0;
      end else if (st) begin
        m_holding = 1; m_hpc = m_addr; m_hinstr = rdata;
      end else begin
        m_fetch++;
        m_addr = m_addr + 32'd4;
      end
    end else if (rd) begin
      m_junk = 1; m_target = rp;
    end
  endtask

  initial begin
    logic [31:0] rp;
    m_addr = 32'h0000_0001;  // marks model as not yet reset
    m_holding = 0; m_junk = 0; m_fetch = 0; m_disc = 0; m_target = 0; m_hpc = 0; m_hinstr = 0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // sequential fetch with immediate responses
    step(0, 0, 0, 0, 1);
    check_eq("r034_addr0", obs_addr, 32'h4000_0000);
    check_eq("r034_pc0", obs_pc, 32'h4000_0000);
    step(0, 0, 0, 0, 1);
    check_eq("r034_pc1", obs_pc, 32'h4000_0004);
    step(0, 0, 0, 0, 1);
    check_eq("r034_pc2", obs_pc, 32'h4000_0008);
    // redirect while request outstanding, response two cycles later
    step(0, 0, 1, 32'h4000_0100, 0);
    step(0, 0, 0, 0, 0);
    check_eq("r036_addr_held", obs_addr, 32'h4000_000C);
    step(0, 0, 0, 0, 1);
    check_eq("r036_dropped", {31'd0, obs_load}, 32'd0);
    step(0, 0, 0, 0, 0);
    check_eq("r036_next_addr", obs_addr, 32'h4000_0100);
`ifdef IF_STAGE_PERF_EN
    check_eq("r039_fetch", fetch_count, 32'd3);
    check_eq("r039_disc", discard_count, 32'd1);
`endif
    // stalled response held for three cycles
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("r035_load", {31'd0, obs_load}, 32'd1);
    check_eq("r035_pc", obs_pc, 32'h4000_0100);
    step(0, 0, 0, 0, 0);
    check_eq("r035_next", obs_addr, 32'h4000_0104);
    // redirect and response together under stall
    step(0, 1, 1, 32'h4000_0400, 1);
    check_eq("r037_load", {31'd0, obs_load}, 32'd0);
    step(0, 0, 0, 0, 0);
    check_eq("r037_next", obs_addr, 32'h4000_0400);
    // two redirects during DISCARD
    step(0, 0, 1, 32'h4000_0200, 0);
    step(0, 0, 1, 32'h4000_0300, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check_eq("r038_next", obs_addr, 32'h4000_0300);
    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 0, 1);
    check_eq("wrap_pc", obs_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    check_eq("wrap_next", obs_addr, 32'h0000_0000);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0)
        rp = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
      else
        rp = {$urandom} & 32'hFFFF_FFFC;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0, rp, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
